// File: rtl/debounce_pulse.sv
// debounce_pulse: turns a raw, bouncing push-button/switch input into a clean
// clock-synchronous level (btn_db) plus single-cycle rise/fall strobes.
// The input is synchronised with two flops, then a four-state FSM requires the
// synchronised value to hold for STABLE_CNT consecutive cycles before it is
// accepted. Any return to the current stable value restarts qualification.
module debounce_pulse #(
    parameter int STABLE_CNT = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_db,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    // Counter only has to reach STABLE_CNT-1, so $clog2 bits are enough.
    localparam int               CNT_W    = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    logic             sync_p0_q;
    logic             sync_p1_q;
    logic             s;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             btn_db_q;
    logic             rise_q;
    logic             fall_q;

    // Two-flop synchroniser: the only logic that ever looks at btn_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0_q <= 1'b0;
            sync_p1_q <= 1'b0;
        end else begin
            sync_p0_q <= btn_in;
            sync_p1_q <= sync_p0_q;
        end
    end

    assign s     = sync_p1_q;
    assign cnt_d = cnt_q + CNT_W'(1);

    // Qualification FSM with registered level and strobe outputs; strobes
    // default low every cycle so they can only last a single clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE_LO;
            cnt_q    <= '0;
            btn_db_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                IDLE_LO: begin
                    if (s) begin
                        state_q <= WAIT_HI;
                        cnt_q   <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        // Bounced back low: drop the candidate, no partial credit.
                        state_q <= IDLE_LO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q  <= IDLE_HI;
                        btn_db_q <= 1'b1;
                        rise_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                IDLE_HI: begin
                    if (!s) begin
                        state_q <= WAIT_LO;
                        cnt_q   <= '0;
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        // Bounced back high: drop the candidate.
                        state_q <= IDLE_HI;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q  <= IDLE_LO;
                        btn_db_q <= 1'b0;
                        fall_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE_LO;
                end
            endcase
        end
    end

    // busy is a pure decode of the state register.
    assign busy       = (state_q == WAIT_HI) || (state_q == WAIT_LO);
    assign btn_db     = btn_db_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Testbench for debounce_pulse (STABLE_CNT=4). The reference model treats the
// design as "synchronise by two cycles, then flip the level once the
// synchronised input has differed from it on STABLE_CNT+1 consecutive edges".
// Expected outputs are queued per clock edge and compared by a separate monitor.
module tb_debounce_pulse;

    localparam int SC = 4;

    typedef struct packed {
        logic db;
        logic rise;
        logic fall;
        logic busy;
    } exp_t;

    logic clk;
    logic rst_n;
    logic btn_in;
    logic btn_db;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    exp_t exp_q[$];
    event async_evt;
    int   checks;
    int   errors;

    // Reference model state
    logic m_p0;
    logic m_p1;
    logic m_db;
    int   m_run;

    debounce_pulse #(.STABLE_CNT(SC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .btn_db     (btn_db),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One model step per rising edge, using the inputs present before the edge.
    task automatic model_step();
        exp_t e;
        logic s;
        e = '0;
        if (!rst_n) begin
            m_p0  = 1'b0;
            m_p1  = 1'b0;
            m_db  = 1'b0;
            m_run = 0;
        end else begin
            s    = m_p1;
            m_p1 = m_p0;
            m_p0 = btn_in;
            if (s != m_db) begin
                m_run++;
                if (m_run == SC + 1) begin
                    m_db  = s;
                    m_run = 0;
                    if (s) e.rise = 1'b1;
                    else   e.fall = 1'b1;
                end
            end else begin
                m_run = 0;
            end
            e.db   = m_db;
            e.busy = (m_run != 0);
        end
        exp_q.push_back(e);
    endtask

    // Advance one edge, then drive the next input values 2 time units later.
    task automatic cycle(input logic b, input logic r);
        @(posedge clk);
        model_step();
        #2;
        btn_in = b;
        rst_n  = r;
    endtask

    // Assert reset between edges and request an immediate output check.
    task automatic async_rst();
        @(posedge clk);
        model_step();
        #2;
        rst_n = 1'b0;
        #1;
        -> async_evt;
    endtask

    task automatic chk(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, expv);
        end
    endtask

    // Monitor: at each falling edge pop one expectation and compare; on an
    // asynchronous reset request (clk high) check that outputs already cleared.
    initial begin
        exp_t e;
        checks = 0;
        errors = 0;
        forever begin
            @(negedge clk or async_evt);
            if (clk) begin
                chk("async_rst_btn_db", btn_db,     1'b0);
                chk("async_rst_rise",   rise_pulse, 1'b0);
                chk("async_rst_fall",   fall_pulse, 1'b0);
                chk("async_rst_busy",   busy,       1'b0);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (!rst_n) e = '0;
                chk("btn_db",     btn_db,     e.db);
                chk("rise_pulse", rise_pulse, e.rise);
                chk("fall_pulse", fall_pulse, e.fall);
                chk("busy",       busy,       e.busy);
            end
        end
    end

    // Stimulus: directed scenarios followed by randomised bouncing.
    initial begin
        logic v;
        int   len;
        rst_n  = 1'b0;
        btn_in = 1'b1;

        // Button held high through reset, then released reset
        repeat (5) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        repeat (20) cycle(1'b1, 1'b1);

        // Clean release
        repeat (12) cycle(1'b0, 1'b1);
        // Clean press
        repeat (20) cycle(1'b1, 1'b1);
        // Short low glitch while accepted high
        repeat (3) cycle(1'b0, 1'b1);
        repeat (12) cycle(1'b1, 1'b1);
        // Back to low
        repeat (12) cycle(1'b0, 1'b1);
        // Bouncing press then hold
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        repeat (15) cycle(1'b1, 1'b1);
        // Back to low, then reset in the middle of qualifying a press
        repeat (12) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b1, 1'b1);
        async_rst();
        repeat (3) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        repeat (50) cycle(1'b0, 1'b1);

        // Randomised segments of random length, with occasional resets
        for (int seg = 0; seg < 250; seg++) begin
            v   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(6, 14))
                                               : int'($urandom_range(1, 6));
            if ($urandom_range(0, 39) == 0) begin
                async_rst();
                repeat (2) cycle(v, 1'b0);
                cycle(v, 1'b1);
            end else begin
                repeat (len) cycle(v, 1'b1);
            end
        end
        repeat (30) cycle(btn_in, 1'b1);

        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
